// File: rtl/div_wb_unit_pkg.sv
// Shared types and constants for the iterative divider / register-file writeback unit.
package div_wb_unit_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG   = 0;
    localparam logic [WIDTH_DEF-1:0] DIV0_QUOT = '1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        ZDIV = 3'd2,
        FIX  = 3'd3,
        WB   = 3'd4
    } state_t;

endpackage

// File: rtl/div_wb_unit_step.sv
// One radix-2 restoring division iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step
    import div_wb_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The partial remainder is always below the divisor, so its top bit is free to act as the borrow.
    assign shifted = {rem_in[WIDTH-1:0], next_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/div_wb_unit.sv
// Multi-cycle signed/unsigned divider that delivers its result as a one-cycle register-file write.
module div_wb_unit
    import div_wb_unit_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              kill,
    input  logic              is_signed,
    input  logic              want_rem,
    input  logic [ADDR_W-1:0] rd,
    input  logic [WIDTH-1:0]  dividend,
    input  logic [WIDTH-1:0]  divisor,
    output logic              busy,
    output logic              done,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_addr_w,
    output logic [WIDTH-1:0]  rf_data_w
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  count_reg;
    logic [WIDTH:0]    rem_reg;
    logic [WIDTH-1:0]  quo_reg;
    logic [WIDTH-1:0]  dvs_reg;
    logic              q_neg_reg, r_neg_reg, want_rem_reg;
    logic [ADDR_W-1:0] rd_reg;

    logic              busy_reg, done_reg, wen_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [WIDTH-1:0]  data_reg;

    logic              busy_next, done_next, wen_next, load_wb;
    logic [WIDTH-1:0]  q_fix, r_fix, wb_data;

    logic              accept;
    logic              dividend_neg, divisor_neg;
    logic [WIDTH-1:0]  dividend_mag, divisor_mag;
    logic [WIDTH:0]    step_rem;
    logic              step_q;

    assign accept       = (state_reg == IDLE) && start && !kill;
    assign dividend_neg = is_signed & dividend[WIDTH-1];
    assign divisor_neg  = is_signed & divisor[WIDTH-1];
    assign dividend_mag = dividend_neg ? -dividend : dividend;
    assign divisor_mag  = divisor_neg  ? -divisor  : divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in   (rem_reg),
        .next_bit (quo_reg[WIDTH-1]),
        .divisor  (dvs_reg),
        .rem_out  (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start && !kill) state_next = (divisor == '0) ? ZDIV : CALC;
            CALC:    if (count_reg == '0) state_next = FIX;
            FIX:     state_next = WB;
            ZDIV:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (kill) state_next = IDLE;
    end

    always_comb begin
        busy_next = (state_next != IDLE);
        load_wb   = (state_next == WB);
        done_next = load_wb;
        wen_next  = load_wb && (rd_reg != ADDR_W'(ZERO_REG));
        q_fix     = q_neg_reg ? -quo_reg : quo_reg;
        r_fix     = r_neg_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
        // On the zero-divisor path quo_reg still holds the raw dividend.
        if (state_reg == ZDIV) wb_data = want_rem_reg ? quo_reg : {WIDTH{DIV0_QUOT[0]}};
        else                   wb_data = want_rem_reg ? r_fix : q_fix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            dvs_reg      <= '0;
            q_neg_reg    <= 1'b0;
            r_neg_reg    <= 1'b0;
            want_rem_reg <= 1'b0;
            rd_reg       <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            wen_reg      <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
        end else begin
            if (accept) begin
                rd_reg       <= rd;
                want_rem_reg <= want_rem;
                q_neg_reg    <= dividend_neg ^ divisor_neg;
                r_neg_reg    <= dividend_neg;
                dvs_reg      <= divisor_mag;
                rem_reg      <= '0;
                count_reg    <= CNT_W'(WIDTH - 1);
                quo_reg      <= (divisor == '0) ? dividend : dividend_mag;
            end else if (state_reg == CALC) begin
                rem_reg   <= step_rem;
                quo_reg   <= {quo_reg[WIDTH-2:0], step_q};
                count_reg <= count_reg - 1'b1;
            end
            busy_reg <= busy_next;
            done_reg <= done_next;
            wen_reg  <= wen_next;
            if (load_wb) begin
                addr_reg <= rd_reg;
                data_reg <= wb_data;
            end
        end
    end

    // A flush arriving during WB must still cancel the write the register file samples mid-cycle.
    assign busy      = busy_reg;
    assign done      = done_reg & ~kill;
    assign rf_wen    = wen_reg & ~kill;
    assign rf_addr_w = addr_reg;
    assign rf_data_w = data_reg;

endmodule

// File: tb/tb_div_wb_unit.sv
// Self-checking bench for div_wb_unit: directed corner cases plus randomized ops against an arithmetic model.
module tb_div_wb_unit;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, kill = 1'b0;
    logic        is_signed = 1'b0, want_rem = 1'b0;
    logic [4:0]  rd = '0;
    logic [31:0] dividend = '0, divisor = '0;
    logic        busy, done, rf_wen;
    logic [4:0]  rf_addr_w;
    logic [31:0] rf_data_w;

    int n_cmp = 0;
    int n_bad = 0;

    div_wb_unit #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kill(kill),
        .is_signed(is_signed), .want_rem(want_rem), .rd(rd),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .rf_wen(rf_wen),
        .rf_addr_w(rf_addr_w), .rf_data_w(rf_data_w)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_div(input logic sg, input logic wr,
                                            input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (b == 32'd0) return wr ? a : 32'hFFFF_FFFF;
        if (sg) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            return wr ? 32'(sa % sb) : 32'(sa / sb);
        end
        return wr ? (a % b) : (a / b);
    endfunction

    task automatic set_op(input logic sg, input logic wr, input logic [4:0] r,
                          input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; is_signed = sg; want_rem = wr; rd = r; dividend = a; divisor = b;
    endtask

    // Issues one op right after a rising edge (edge 0) and observes 40 following cycles at negedge.
    task automatic do_op(input logic sg, input logic wr, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] b,
                         output int n_wen, output int n_done, output int wb_edge,
                         output logic b1, output logic [31:0] d, output logic [4:0] ad);
        @(posedge clk); #1;
        set_op(sg, wr, r, a, b);
        n_wen = 0; n_done = 0; wb_edge = -1; b1 = 1'b0; d = 'x; ad = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (k == 1) b1 = busy;
            if (done) begin n_done++; wb_edge = k; end
            if (rf_wen) begin n_wen++; d = rf_data_w; ad = rf_addr_w; end
        end
    endtask

    task automatic test_reset;
        #2;
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (rf_wen !== 1'b0)    begin n_bad++; $display("FAIL reset_wen: got %b want 0", rf_wen); end
        n_cmp++; if (rf_addr_w !== 5'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", rf_addr_w); end
        n_cmp++; if (rf_data_w !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", rf_data_w); end
        $display("reset: busy=%b done=%b wen=%b addr=%0d data=%h", busy, done, rf_wen, rf_addr_w, rf_data_w);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_op(input string nm, input logic sg, input logic wr, input logic [4:0] r,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_d);
        int nw, nd, we; logic b1; logic [31:0] d; logic [4:0] ad; int exp_edge;
        exp_edge = (b == 32'd0) ? 2 : 34;
        do_op(sg, wr, r, a, b, nw, nd, we, b1, d, ad);
        $display("%s: s=%b rem=%b rd=%0d %h/%h -> data=%h addr=%0d wb_edge=%0d writes=%0d",
                 nm, sg, wr, r, a, b, d, ad, we, nw);
        n_cmp++; if (b1 !== 1'b1)  begin n_bad++; $display("FAIL %s_busy: got %b want 1", nm, b1); end
        n_cmp++; if (nw != 1 || nd != 1) begin n_bad++; $display("FAIL %s_pulses: got wen=%0d done=%0d want 1/1", nm, nw, nd); end
        n_cmp++; if (we != exp_edge) begin n_bad++; $display("FAIL %s_latency: got edge %0d want %0d", nm, we, exp_edge); end
        n_cmp++; if (d !== exp_d)  begin n_bad++; $display("FAIL %s_data: got %h want %h", nm, d, exp_d); end
        n_cmp++; if (ad !== r)     begin n_bad++; $display("FAIL %s_addr: got %0d want %0d", nm, ad, r); end
    endtask

    task automatic test_directed;
        logic        sg [0:11] = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
        logic        wr [0:11] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        logic [4:0]  rr [0:11] = '{5, 5, 3, 3, 3, 3, 9, 9, 7, 7, 8, 8};
        logic [31:0] aa [0:11] = '{100, 100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 7, 7,
                                   32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'h1234_5678,
                                   32'h8765_4321, 32'h8765_4321};
        logic [31:0] bb [0:11] = '{7, 7, 2, 2, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0};
        logic [31:0] ee [0:11] = '{14, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1,
                                   32'h8000_0000, 0, 32'hFFFF_FFFF, 32'h1234_5678,
                                   32'hFFFF_FFFF, 32'h8765_4321};
        for (int i = 0; i < 12; i++) check_op($sformatf("dir%0d", i), sg[i], wr[i], rr[i], aa[i], bb[i], ee[i]);
    endtask

    task automatic test_random;
        logic sg, wr; logic [4:0] r; logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            sg = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            r  = 5'($urandom_range(1, 31));
            a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            check_op($sformatf("rnd%0d", i), sg, wr, r, a, b, ref_div(sg, wr, a, b));
        end
    endtask

    task automatic test_rd_zero;
        int nw, nd, we; logic b1; logic [31:0] d; logic [4:0] ad;
        do_op(1'b0, 1'b0, 5'd0, 32'd100, 32'd7, nw, nd, we, b1, d, ad);
        $display("rd_zero: done_pulses=%0d writes=%0d wb_edge=%0d", nd, nw, we);
        n_cmp++; if (nd != 1) begin n_bad++; $display("FAIL rd0_done: got %0d want 1", nd); end
        n_cmp++; if (nw != 0) begin n_bad++; $display("FAIL rd0_wen: got %0d want 0", nw); end
    endtask

    task automatic test_kill;
        int nw, nd;
        // Flush in the middle of CALC.
        @(posedge clk); #1;
        set_op(1'b0, 1'b0, 5'd6, 32'd1000, 32'd3);
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1 kill = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL kill_calc_busy: got %b want 0", busy); end
        nw = 0; nd = 0;
        for (int k = 0; k < 40; k++) begin @(negedge clk); nw += int'(rf_wen); nd += int'(done); end
        $display("kill_calc: busy=%b writes=%0d done=%0d", busy, nw, nd);
        n_cmp++; if (nw != 0 || nd != 0) begin n_bad++; $display("FAIL kill_calc_out: got wen=%0d done=%0d want 0/0", nw, nd); end
        // Flush presented alongside start in IDLE.
        @(posedge clk); #1;
        set_op(1'b0, 1'b0, 5'd6, 32'd10, 32'd3); kill = 1'b1;
        @(posedge clk); #1 start = 1'b0; kill = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL kill_idle_busy: got %b want 0", busy); end
        $display("kill_idle: busy=%b", busy);
        // Flush during WB gates the write combinationally.
        @(posedge clk); #1;
        set_op(1'b0, 1'b0, 5'd6, 32'd10, 32'd0);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL kill_wb_pre: got done=%b want 1", done); end
        kill = 1'b1; #1;
        $display("kill_wb: wen=%b done=%b", rf_wen, done);
        n_cmp++; if (rf_wen !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL kill_wb_gate: got wen=%b done=%b want 0/0", rf_wen, done); end
        @(posedge clk); #1 kill = 1'b0;
        n_cmp++; if (busy !== 1'b0 || rf_wen !== 1'b0) begin n_bad++; $display("FAIL kill_wb_after: got busy=%b wen=%b want 0/0", busy, rf_wen); end
    endtask

    task automatic test_back_to_back;
        int nw, nd; logic [31:0] d; logic b_after;
        @(posedge clk); #1;
        set_op(1'b0, 1'b0, 5'd11, 32'd100, 32'd7);
        nw = 0; nd = 0; d = 'x; b_after = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            start = (k == 5) || (k == 34);
            if (start) begin dividend = 32'd999; divisor = 32'd2; rd = 5'd12; end
            if (k == 36) b_after = busy;
            @(negedge clk);
            if (rf_wen) begin nw++; d = rf_data_w; end
            nd += int'(done);
        end
        start = 1'b0;
        $display("back_to_back: writes=%0d done=%0d data=%h busy_after=%b", nw, nd, d, b_after);
        n_cmp++; if (nw != 1 || nd != 1) begin n_bad++; $display("FAIL b2b_count: got wen=%0d done=%0d want 1/1", nw, nd); end
        n_cmp++; if (d !== 32'd14) begin n_bad++; $display("FAIL b2b_data: got %h want %h", d, 32'd14); end
        n_cmp++; if (b_after !== 1'b0) begin n_bad++; $display("FAIL b2b_wb_start: got busy=%b want 0", b_after); end
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        set_op(1'b1, 1'b1, 5'd4, 32'hFFFF_FFF9, 32'd2);
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        $display("reset_mid: busy=%b wen=%b done=%b addr=%0d data=%h", busy, rf_wen, done, rf_addr_w, rf_data_w);
        n_cmp++; if (busy !== 1'b0 || rf_wen !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rstmid_ctrl: got busy=%b wen=%b done=%b want 0/0/0", busy, rf_wen, done); end
        n_cmp++; if (rf_data_w !== 32'd0 || rf_addr_w !== 5'd0) begin n_bad++; $display("FAIL rstmid_data: got addr=%0d data=%h want 0/0", rf_addr_w, rf_data_w); end
        @(negedge clk); rst_n = 1'b1;
        check_op("post_rst", 1'b0, 1'b0, 5'd5, 32'd100, 32'd7, 32'd14);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_rd_zero;
        test_kill;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
